// File: rtl/kp_pkg.sv
// Shared constants and encodings for the 4x4 matrix keypad scanner.
package kp_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam logic [3:0] COL0     = 4'b1110;
  localparam logic [3:0] COL1     = 4'b1101;
  localparam logic [3:0] COL2     = 4'b1011;
  localparam logic [3:0] COL3     = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } kp_result_e;

  function automatic logic [3:0] col_next(input logic [3:0] c);
    case (c)
      COL0:    return COL1;
      COL1:    return COL2;
      COL2:    return COL3;
      default: return COL0;
    endcase
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      COL1:    return 2'd1;
      COL2:    return 2'd2;
      COL3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the active-low keypad row lines; idles released (all ones).
module kp_sync2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-hot-low column rotation, per-sweep classification,
// sweep-level debounce of press and release with a one-cycle valid strobe.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_SWEEPS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             multi_key
);

  localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEB_SWEEPS);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       col_q;
  logic [1:0]       acc_cnt_q;
  logic [KEY_W-1:0] acc_code_q;
  kp_state_e        state_q;
  logic [KEY_W-1:0] cand_q;
  logic [3:0]       stab_q;
  logic [3:0]       rel_q;
  logic [KEY_W-1:0] key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic             multi_q;

  logic             tick;
  logic             sample;
  logic             sweep_end;
  logic [2:0]       col_hits;
  logic [1:0]       col_row;
  logic [2:0]       hit_sum;
  logic [1:0]       acc_cnt_d;
  logic [KEY_W-1:0] acc_code_d;
  kp_result_e       result;
  logic [3:0]       stab_inc;
  logic [3:0]       rel_inc;

  kp_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (row),
    .q_o     (row_s)
  );

  assign tick      = (div_q == DIV_LAST);
  assign sample    = tick && (col_q != COL_IDLE);
  assign sweep_end = tick && (col_q == COL3);
  assign stab_inc  = stab_q + 4'd1;
  assign rel_inc   = rel_q + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      col_q <= COL_IDLE;
    end else if (tick) begin
      div_q <= '0;
      col_q <= col_next(col_q);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Hit count saturates at 2; the code is only meaningful while exactly one key has been seen.
  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    hit_sum    = {1'b0, acc_cnt_q} + col_hits;
    acc_cnt_d  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    acc_code_d = (acc_cnt_q == 2'd0) ? {col_row, col_index(col_q)} : acc_code_q;
    case (acc_cnt_d)
      2'd0:    result = NONE;
      2'd1:    result = SINGLE;
      default: result = MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (sweep_end) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (sample) begin
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      stab_q      <= '0;
      rel_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (sweep_end) begin
        multi_q <= (result == MULTI);
        unique case (state_q)
          IDLE: begin
            if (result == SINGLE) begin
              cand_q <= acc_code_d;
              stab_q <= 4'd1;
              if (DEB_N == 4'd1) begin
                key_code_q  <= acc_code_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= HELD;
              end else begin
                state_q <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (result != SINGLE) begin
              state_q <= IDLE;
            end else if (acc_code_d == cand_q) begin
              stab_q <= stab_inc;
              if (stab_inc == DEB_N) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= HELD;
              end
            end else begin
              cand_q <= acc_code_d;
              stab_q <= 4'd1;
            end
          end
          HELD: begin
            if (result == NONE) begin
              rel_q <= 4'd1;
              if (DEB_N == 4'd1) begin
                key_held_q <= 1'b0;
                state_q    <= IDLE;
              end else begin
                state_q <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (result == NONE) begin
              rel_q <= rel_inc;
              if (rel_inc == DEB_N) begin
                key_held_q <= 1'b0;
                state_q    <= IDLE;
              end
            end else begin
              state_q <= HELD;
            end
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_q;

endmodule
